fa_20bit_adder: RTL and testbench

- Parameterized ripple-carry binary adder, default 20 bits: computes {cout, S} = A + B + cin combinationally.
- Also provides a registered copy of the result plus a signed-overflow flag, updated on each clk rising edge.
- Used as a datapath leaf wherever a full-width add with carry-in/carry-out is needed.

---
 rtl/fa_pkg.sv | 16 +
 rtl/fa_cell.sv | 14 +
 rtl/fa_20bit_adder.sv | 119 +++++++++++
 tb/tb_fa_20bit_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants for the fa_20bit_adder datapath leaf and a plain-arithmetic
// reference sum used by scoreboards.
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 20;
  localparam int CLA_GROUP        = 4;

  function automatic logic [FA_DEFAULT_WIDTH:0] ref_add(
    input logic [FA_DEFAULT_WIDTH-1:0] a,
    input logic [FA_DEFAULT_WIDTH-1:0] b,
    input logic                        cin
  );
    return {1'b0, a} + {1'b0, b} + {{FA_DEFAULT_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder cell: s = a^b^ci, co = majority(a, b, ci).
// Purely combinational, no clock, no flow control.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa_20bit_adder.sv
// Width-parameterised adder {cout,S} = A+B+cin with signed overflow; S/cout/ovf
// are combinational (0 cycles), S_q/cout_q/ovf_q follow one clk later, no stall.
// FA_20BIT_CLA_EN selects 4-bit carry-lookahead groups instead of pure ripple.
module fa_20bit_adder
  import fa_pkg::*;
#(
  parameter int width = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             cin,
  output logic [width-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic [width-1:0] S_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // c[i] is the carry into bit i; c[width] is the carry out of the MSB.
  logic [width:0] c;

  assign c[0] = cin;

`ifdef FA_20BIT_CLA_EN

  localparam int NUM_GRP = (width + CLA_GROUP - 1) / CLA_GROUP;

  logic [width-1:0] g;
  logic [width-1:0] p;
  logic [width-1:0] cell_co;

  assign g = A & B;
  assign p = A ^ B;

  // Carry out of bit n-1 of a group, as a flat sum of products of g/p and the
  // group carry-in, so every bit carry in the group resolves in parallel.
  function automatic logic la_carry(
    input logic [CLA_GROUP-1:0] gg,
    input logic [CLA_GROUP-1:0] pp,
    input logic                 ci,
    input int                   n
  );
    logic r;
    logic t;
    r = 1'b0;
    for (int j = 0; j <= n; j++) begin
      t = (j == 0) ? ci : gg[j-1];
      for (int m = j; m < n; m++) begin
        t = t & pp[m];
      end
      r = r | t;
    end
    return r;
  endfunction

  for (genvar grp = 0; grp < NUM_GRP; grp++) begin : g_grp
    localparam int LO = grp * CLA_GROUP;
    localparam int SZ = ((width - LO) < CLA_GROUP) ? (width - LO) : CLA_GROUP;

    logic [CLA_GROUP-1:0] gg;
    logic [CLA_GROUP-1:0] pp;

    always_comb begin
      gg = '0;
      pp = '0;
      for (int i = 0; i < SZ; i++) begin
        gg[i] = g[LO+i];
        pp[i] = p[LO+i];
      end
    end

    for (genvar k = 0; k < SZ; k++) begin : g_bit
      assign c[LO+k+1] = la_carry(gg, pp, c[LO], k + 1);
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_sum
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (cell_co[i])
    );
  end

`else

  for (genvar i = 0; i < width; i++) begin : g_ripple
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

`endif

  assign cout = c[width];
  assign ovf  = c[width-1] ^ c[width];

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      S_q    <= S;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_fa_20bit_adder.sv
// Bench for fa_20bit_adder: directed corner vectors plus random vectors against
// an arithmetic model, at the default width and at width 8.
module tb_fa_20bit_adder;
  import fa_pkg::*;

  localparam int W = FA_DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] S, S_q;
  logic         cout, ovf, cout_q, ovf_q;

  logic [7:0]   A8 = '0, B8 = '0;
  logic         cin8 = 1'b0;
  logic [7:0]   S8, S8_q;
  logic         cout8, ovf8, cout8_q, ovf8_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_20bit_adder dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin),
    .S(S), .cout(cout), .ovf(ovf),
    .S_q(S_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  fa_20bit_adder #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .A(A8), .B(B8), .cin(cin8),
    .S(S8), .cout(cout8), .ovf(ovf8),
    .S_q(S8_q), .cout_q(cout8_q), .ovf_q(ovf8_q)
  );

  // Signed overflow from the two's-complement range, not from carries.
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
    longint sa, sb, sum;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sum = sa + sb + longint'(c);
    return (sum > (longint'(1) <<< (W-1)) - 1) || (sum < -(longint'(1) <<< (W-1)));
  endfunction

  function automatic logic model_ovf8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int sum;
    sum = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (sum > 127) || (sum < -128);
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    A = a; B = b; cin = c;
    #10;
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W-1:0] exp_s, input logic exp_co,
                           input logic exp_ov);
    apply(a, b, c);
    checks++;
    if ({cout, S, ovf} !== {exp_co, exp_s, exp_ov}) begin
      errors++;
      $display("FAIL %s: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
               name, S, cout, ovf, exp_s, exp_co, exp_ov);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; A = 20'hABCDE; B = 20'h12345; cin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({S_q, cout_q, ovf_q} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got S_q=%h cout_q=%b ovf_q=%b, want all 0", S_q, cout_q, ovf_q);
    end
    checks++;
    if ({cout, S} !== 21'h0BE024) begin
      errors++;
      $display("FAIL reset_comb: got {cout,S}=%h, want 0be024", {cout, S});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp;
    int           bad;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = ref_add(a, b, c);
      apply(a, b, c);
      checks++;
      if ({cout, S} !== exp || ovf !== model_ovf(a, b, c)) begin
        errors++; bad++;
        $display("FAIL random[%0d]: A=%h B=%h cin=%b got {cout,S}=%h ovf=%b, want %h ovf=%b",
                 i, a, b, c, {cout, S}, ovf, exp, model_ovf(a, b, c));
      end
    end
    $display("random: %0d%% of 50 vectors matched", ((50 - bad) * 100) / 50);
  endtask

  task automatic test_wrap();
    check_vec("wrap_ones_plus_cin", 20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0);
    check_vec("wrap_ones_ones_cin", 20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0);
    check_vec("all_zero",           20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0);
  endtask

  task automatic test_signed_overflow();
    check_vec("ovf_pos", 20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1);
    check_vec("ovf_neg", 20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1);
    check_vec("no_ovf_mixed", 20'h7FFFF, 20'h80000, 1'b1, 20'h00000, 1'b1, 1'b0);
  endtask

  task automatic test_carry_in();
    check_vec("cin_only", 20'h00000, 20'h00000, 1'b1, 20'h00001, 1'b0, 1'b0);
    check_vec("plain_add", 20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 1'b0);
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0; A = 20'hFFFFF; B = 20'h00001; cin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({S_q, cout_q, ovf_q} !== {20'h00000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reg_capture: got S_q=%h cout_q=%b ovf_q=%b, want 00000 1 0", S_q, cout_q, ovf_q);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({S_q, cout_q, ovf_q} !== '0) begin
      errors++;
      $display("FAIL reg_reset: got S_q=%h cout_q=%b ovf_q=%b, want all 0", S_q, cout_q, ovf_q);
    end
    checks++;
    if ({cout, S} !== {1'b1, 20'h00000}) begin
      errors++;
      $display("FAIL comb_during_rst: got {cout,S}=%h, want 100000", {cout, S});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (i == 0) begin a = 20'h80000; b = 20'hFFFFF; c = 1'b0; end
      A = a; B = b; cin = c;
      exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      @(posedge clk); #1;
      checks++;
      if ({cout_q, S_q, ovf_q} !== {exp, model_ovf(a, b, c)}) begin
        errors++;
        $display("FAIL b2b[%0d]: got {cout_q,S_q}=%h ovf_q=%b, want %h ovf_q=%b",
                 i, {cout_q, S_q}, ovf_q, exp, model_ovf(a, b, c));
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    A8 = 8'hFF; B8 = 8'h01; cin8 = 1'b0;
    #10;
    checks++;
    if ({cout8, S8, ovf8} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL w8_wrap: got cout=%b S=%h ovf=%b, want 1 00 0", cout8, S8, ovf8);
    end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      A8 = a; B8 = b; cin8 = c;
      #10;
      exp = 9'(a) + 9'(b) + 9'(c);
      checks++;
      if ({cout8, S8} !== exp || ovf8 !== model_ovf8(a, b, c)) begin
        errors++;
        $display("FAIL w8_random[%0d]: got {cout,S}=%h ovf=%b, want %h ovf=%b",
                 i, {cout8, S8}, ovf8, exp, model_ovf8(a, b, c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_wrap();
    test_signed_overflow();
    test_carry_in();
    test_registered();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
